program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter PC_W, default 10, meaning width of pc and branch address.
REQ-002 SHALL have parameter START_ADDR, default 0, meaning first instruction address of a program.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of cycle_count.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to begin (or restart) a program.
REQ-007 SHALL have port stall  input  1  freeze pc and FSM for this cycle.
REQ-008 SHALL have port halt_instr  input  1  current instruction is a halt.
REQ-009 SHALL have port branch  input  1  take branch this cycle (from Branch).
REQ-010 SHALL have port address  input  PC_W  branch target (from Branch).
REQ-011 SHALL have port pc  output  PC_W  address of instruction to fetch.
REQ-012 SHALL have port running  output  1  high while in RUN.
REQ-013 SHALL have port done  output  1  high while in DONE.
REQ-014 SHALL have port cycle_count  output  CNT_W  cycles spent in RUN for the current program.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, RUN, DONE; running/done decoded from state only (no combinational path from inputs).
REQ-016 IDLE: pc holds START_ADDR; start=1 -> RUN next cycle, pc=START_ADDR, cycle_count=0.
REQ-017 RUN with stall=1: pc, state, cycle_count all hold; halt_instr, branch, start ignored.
REQ-018 RUN with stall=0, priority halt_instr > branch > sequential.
REQ-019 RUN, stall=0, halt_instr=1: -> DONE; pc holds (points at halt); cycle_count increments once.
REQ-020 RUN, stall=0, halt_instr=0, branch=1: pc <= address; cycle_count increments.
REQ-021 RUN, stall=0, halt_instr=0, branch=0: pc <= pc+1 modulo 2^PC_W (all-ones wraps to 0); cycle_count increments.
REQ-022 start asserted during RUN SHALL be ignored.
REQ-023 cycle_count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-024 DONE: pc and cycle_count hold; start=1 -> RUN next cycle with pc=START_ADDR, cycle_count=0.
REQ-025 branch=1 outside RUN SHALL have no effect on pc.
REQ-026 Latency: control inputs sampled at edge N take effect on pc at edge N (visible after edge N); one instruction per unstalled cycle.

Reset
REQ-027 reset=0 SHALL immediately (asynchronously) force state=IDLE, pc=START_ADDR, cycle_count=0, running=0, done=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the program; after release the block waits in IDLE for start.
REQ-029 Reset release SHALL be treated as synchronous to clk by the integrator; no start taken on the release edge unless start=1 at that edge.

Verification
REQ-030 Reset then start pulse, no branch/halt, 5 cycles -> pc sequence 0,1,2,3,4,5; running=1; cycle_count=5.
REQ-031 In RUN at pc=7, branch=1, address=28 -> pc=28 next cycle, then 29; branch and halt_instr both 1 same cycle -> DONE, pc holds.
REQ-032 In RUN at pc=12, stall=1 for 3 cycles with branch=1, address=40 -> pc stays 12, cycle_count unchanged; after stall released with branch=0 -> pc=13.
REQ-033 pc=1023 (PC_W=10), no branch -> pc=0 next cycle, still RUN.
REQ-034 halt_instr=1 after 9 cycles -> done=1, running=0, cycle_count=10 held; start -> pc=0, cycle_count=0, running=1.
REQ-035 reset=0 asserted between clock edges mid-RUN at pc=52 -> pc=0, state IDLE, outputs cleared before next edge; start ignored during RUN verified.

Source files
------------

// File: rtl/program_counter.sv
// Program counter with IDLE/RUN/DONE sequencing.
// Fetch address advances one instruction per unstalled RUN cycle, jumps on branch,
// freezes on halt. Counts RUN cycles for the current program, saturating at all-ones.
module program_counter #(
    parameter int unsigned    PC_W       = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int unsigned    CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_instr,
    input  logic             branch,
    input  logic [PC_W-1:0]  address,
    output logic [PC_W-1:0]  pc,
    output logic             running,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q;

    // Saturating increment so long programs report the ceiling instead of wrapping.
    logic [CNT_W-1:0] count_inc;
    always_comb begin
        count_inc = cycle_count;
        if (cycle_count != {CNT_W{1'b1}}) begin
            count_inc = cycle_count + CNT_W'(1);
        end
    end

    // State, pc, cycle counter and the registered status flags all advance together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            pc          <= START_ADDR;
            cycle_count <= '0;
            running     <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    pc <= START_ADDR;
                    if (start) begin
                        state_q     <= StRun;
                        cycle_count <= '0;
                        running     <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                StRun: begin
                    // start is deliberately ignored here; a program can only be
                    // restarted once it has reached DONE (or via reset).
                    if (!stall) begin
                        cycle_count <= count_inc;
                        if (halt_instr) begin
                            // pc stays on the halt instruction
                            state_q <= StDone;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end else if (branch) begin
                            pc <= address;
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        state_q     <= StRun;
                        pc          <= START_ADDR;
                        cycle_count <= '0;
                        running     <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                default: begin
                    // Unused encoding: fall back to a clean idle state.
                    state_q     <= StIdle;
                    pc          <= START_ADDR;
                    cycle_count <= '0;
                    running     <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: a reference model pushes expected
// outputs when stimulus is driven; a monitor pops and compares after each edge.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic        start, stall, halt_instr, branch;
    logic [9:0]  address;
    logic [9:0]  pc;
    logic        running, done;
    logic [15:0] cycle_count;

    // Small instance for saturation, wrap and non-zero start address.
    logic        s_start;
    logic [3:0]  s_pc;
    logic        s_running, s_done;
    logic [2:0]  s_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [9:0]  pc;
        logic        running;
        logic        done;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state (0 idle, 1 run, 2 done)
    int          m_state;
    logic [9:0]  m_pc;
    logic [15:0] m_cnt;

    program_counter #(
        .PC_W       (10),
        .START_ADDR (10'd0),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .halt_instr  (halt_instr),
        .branch      (branch),
        .address     (address),
        .pc          (pc),
        .running     (running),
        .done        (done),
        .cycle_count (cycle_count)
    );

    program_counter #(
        .PC_W       (4),
        .START_ADDR (4'd3),
        .CNT_W      (3)
    ) dut_small (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .stall       (1'b0),
        .halt_instr  (1'b0),
        .branch      (1'b0),
        .address     (4'd0),
        .pc          (s_pc),
        .running     (s_running),
        .done        (s_done),
        .cycle_count (s_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and queue the expected result.
    task automatic step(input logic s, input logic st, input logic h, input logic b,
                        input logic [9:0] a);
        @(negedge clk);
        start = s; stall = st; halt_instr = h; branch = b; address = a;
        case (m_state)
            0: begin
                m_pc = 10'd0;
                if (s) begin
                    m_state = 1;
                    m_cnt   = 16'd0;
                end
            end
            1: begin
                if (!st) begin
                    if (h) m_state = 2;
                    else if (b) m_pc = a;
                    else m_pc = m_pc + 10'd1;
                    if (m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
                end
            end
            default: begin
                if (s) begin
                    m_state = 1;
                    m_pc    = 10'd0;
                    m_cnt   = 16'd0;
                end
            end
        endcase
        sb.push_back('{pc: m_pc, running: (m_state == 1), done: (m_state == 2), cnt: m_cnt});
    endtask

    // Wait until the monitor has consumed the last pushed expectation.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor: compare one expectation per rising edge, sampled 1 unit after.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_pc", 32'(pc), 32'(e.pc));
                check("sb_running", 32'(running), 32'(e.running));
                check("sb_done", 32'(done), 32'(e.done));
                check("sb_count", 32'(cycle_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 0; stall = 0; halt_instr = 0; branch = 0; address = '0;
        s_start = 0;
        m_state = 0; m_pc = '0; m_cnt = '0;
        #2;
        reset = 1'b0;
        #1;
        check("rst_pc", 32'(pc), 0);
        check("rst_running", 32'(running), 0);
        check("rst_done", 32'(done), 0);
        check("rst_count", 32'(cycle_count), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Idle: branch has no effect
        step(0, 0, 0, 1, 10'd99);
        step(0, 0, 0, 0, 10'd0);
        // Start, then five sequential instructions
        step(1, 0, 0, 0, 10'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 10'd0);
        settle();
        check("seq_pc5", 32'(pc), 5);
        check("seq_count5", 32'(cycle_count), 5);
        // Advance to pc=7, branch to 28, then 29, then halt+branch together
        step(0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 1, 10'd28);
        step(0, 0, 0, 0, 10'd0);
        step(0, 0, 1, 1, 10'd50);
        step(0, 0, 0, 1, 10'd77);
        settle();
        check("halt_pc_hold", 32'(pc), 29);
        check("halt_done", 32'(done), 1);

        // Restart, branch to 12, stall 3 cycles with branch/halt/start active
        step(1, 0, 0, 0, 10'd0);
        step(0, 0, 0, 1, 10'd12);
        for (int i = 0; i < 3; i++) step(1, 1, i == 1, 1, 10'd40);
        step(0, 0, 0, 0, 10'd0);
        settle();
        check("stall_release_pc", 32'(pc), 13);
        // Wrap from all-ones
        step(0, 0, 0, 1, 10'd1023);
        step(0, 0, 0, 0, 10'd0);
        settle();
        check("wrap_pc", 32'(pc), 0);
        check("wrap_running", 32'(running), 1);
        // start in RUN is ignored
        step(1, 0, 0, 0, 10'd0);

        // Finish, restart, run 9 cycles then halt
        step(0, 0, 1, 0, 10'd0);
        step(1, 0, 0, 0, 10'd0);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 10'd0);
        step(0, 0, 1, 0, 10'd0);
        step(0, 0, 0, 0, 10'd0);
        settle();
        check("halt10_count", 32'(cycle_count), 10);
        check("halt10_running", 32'(running), 0);
        step(1, 0, 0, 0, 10'd0);
        settle();
        check("restart_count", 32'(cycle_count), 0);
        check("restart_running", 32'(running), 1);

        // Async reset mid-RUN at pc=52
        step(0, 0, 0, 1, 10'd52);
        settle();
        check("pre_reset_pc", 32'(pc), 52);
        #1;
        reset = 1'b0;
        #1;
        check("async_pc", 32'(pc), 0);
        check("async_running", 32'(running), 0);
        check("async_done", 32'(done), 0);
        check("async_count", 32'(cycle_count), 0);
        m_state = 0; m_pc = '0; m_cnt = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        // Waits in IDLE until start
        step(0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 10'd0);
        step(1, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 10'd0);
        step(0, 0, 0, 0, 10'd0);
        settle();
        check("sb_drained", 32'(sb.size()), 0);

        // Small instance: non-zero start, counter saturation, pc wrap
        check("small_idle_pc", 32'(s_pc), 3);
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        check("small_start_pc", 32'(s_pc), 3);
        check("small_start_running", 32'(s_running), 1);
        check("small_start_count", 32'(s_count), 0);
        repeat (13) @(negedge clk);
        check("small_wrap_pc", 32'(s_pc), 0);
        check("small_sat_count", 32'(s_count), 7);
        check("small_done", 32'(s_done), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
